cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_pkg.sv | 8 +
 rtl/cordic_lookup.sv | 18 +
 rtl/cordic_vectoring.sv | 93 +++++++++
 tb/tb_cordic_vectoring.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, angle constants and FSM states for the CORDIC vectoring block.
package cordic_pkg;
    localparam int ITER_MAX = 7;
    localparam int ANGLE_90 = 100;
    localparam int XW = 11;
    localparam int ZW = 9;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;
endpackage

// File: rtl/cordic_lookup.sv
// cordic_lookup: arctangent table, atan(2^-i) in units of 0.9 degree.
module cordic_lookup (
    input  logic [2:0]        idx,
    output logic signed [7:0] angle
);
    always_comb begin
        case (idx)
            3'd0:    angle = 8'sd50;
            3'd1:    angle = 8'sd30;
            3'd2:    angle = 8'sd16;
            3'd3:    angle = 8'sd8;
            3'd4:    angle = 8'sd4;
            3'd5:    angle = 8'sd2;
            3'd6:    angle = 8'sd1;
            default: angle = 8'sd0;
        endcase
    end
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC vectoring, atan2(y,x) and magnitude of one vector at a time.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that removes the ~1.647 CORDIC gain from mag_out.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = 7,
    parameter int IW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] x_in,
    input  logic signed [IW-1:0] y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [8:0]    angle_out,
    output logic [9:0]           mag_out
);
`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t AFTER_ITER = S_COMP;
`else
    localparam state_t AFTER_ITER = S_DONE;
`endif

    state_t state, state_nx;
    logic signed [XW-1:0] x, y, xs, ys, dx, dy;
    logic signed [ZW-1:0] z, ae;
    logic signed [7:0] atan;
    logic [2:0] cnt;
    logic last, zero;

    cordic_lookup u_lookup (.idx(cnt), .angle(atan));

    assign xs = XW'(x_in);
    assign ys = XW'(y_in);
    assign ae = ZW'(atan);
    assign dx = y >>> cnt;
    assign dy = x >>> cnt;
    assign last = cnt == 3'(ITER - 1);
    // A zero vector never leaves the y>=0 branch, so freeze z to report angle 0
    assign zero = (x == '0) && (y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = in_valid ? S_ITER : S_IDLE;
            S_ITER:  state_nx = last ? AFTER_ITER : S_ITER;
            S_COMP:  state_nx = S_DONE;
            S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == S_IDLE;
        out_valid = state == S_DONE;
        angle_out = z;
        mag_out   = x[9:0];
    end

    // Pre-rotation folds the left half-plane into |angle| <= 90 deg before iterating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x   <= '0;
            y   <= '0;
            z   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x   <= !xs[XW-1] ? xs : !ys[XW-1] ? ys : -ys;
                    y   <= !xs[XW-1] ? ys : !ys[XW-1] ? -xs : xs;
                    z   <= !xs[XW-1] ? '0 : !ys[XW-1] ? ZW'(ANGLE_90) : -ZW'(ANGLE_90);
                    cnt <= '0;
                end
                S_ITER: begin
                    x   <= y[XW-1] ? x - dx : x + dx;
                    y   <= y[XW-1] ? y + dy : y - dy;
                    z   <= zero ? z : y[XW-1] ? z - ae : z + ae;
                    cnt <= cnt + 3'd1;
                end
                S_COMP: x <= (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed vectors with a result scoreboard for cordic_vectoring.
// Honours CORDIC_GAIN_COMP_EN for expected latency and magnitude scaling.
module tb_cordic_vectoring;
    localparam int ITER = 7;
    localparam int IW = 8;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 2;
    localparam bit COMP = 1'b1;
    localparam int TM = 2;
`else
    localparam int LAT = ITER + 1;
    localparam bit COMP = 1'b0;
    localparam int TM = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [IW-1:0] x_in = '0;
    logic signed [IW-1:0] y_in = '0;
    logic in_ready, out_valid;
    logic signed [8:0] angle_out;
    logic [9:0] mag_out;

    typedef struct {int ang; int mag; int t0;} exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;

    cordic_vectoring #(.ITER(ITER), .IW(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle_out(angle_out), .mag_out(mag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gain(input int m);
        return COMP ? (m >>> 1) + (m >>> 3) - (m >>> 6) - (m >>> 9) : m;
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    // Expected values are hand-iterated raw CORDIC results (uncompensated x, z)
    task automatic send(input int xv, input int yv, input int ang, input int mag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            x_in = IW'(xv);
            y_in = IW'(yv);
            in_valid = 1'b1;
            sbq.push_back('{ang, gain(mag), cyc});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending", sbq.size());
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: angle %0d mag %0d, expected none", angle_out, mag_out);
            end else begin
                if (!prev_ov) check("latency", cyc - sbq[0].t0, LAT, 0);
                check("angle", int'(angle_out), sbq[0].ang, 2);
                check("mag", int'(mag_out), sbq[0].mag, TM);
                check("in_ready_busy", int'(in_ready), 0, 0);
                if (out_ready) void'(sbq.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        int n;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_angle", int'(angle_out), 0, 0);
        check("rst_mag", int'(mag_out), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1, 0);

        send(100, 100, 49, 236);
        send(0, 100, 101, 165);
        send(-100, -1, -201, 167);
        send(0, 0, 0, 0);
        send(-128, 0, 201, 212);
        drain();

        // Hold the result for several cycles and try to sneak in another vector
        out_ready = 1'b0;
        send(100, 100, 49, 236);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_reached_done", int'(out_valid), 1, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            x_in = 8'sd5;
            y_in = 8'sd5;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_in_ready_after", int'(in_ready), 1, 0);
        check("stall_pending", sbq.size(), 0, 0);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Abort a vector with reset during iteration step 3
        x_in = 8'sd100;
        y_in = 8'sd100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_angle", int'(angle_out), 0, 0);
        check("abort_mag", int'(mag_out), 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | int'(out_valid);
        end
        check("abort_no_result", seen, 0, 0);
        check("abort_in_ready", int'(in_ready), 1, 0);

        send(50, -50, -51, 120);
        drain();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
